// File: rtl/nios2_debug_slave_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios2_debug_pkg
// Purpose  : Shared types and constants for the Nios II debug command decoder.
// Revision : 1.0 - initial release
// ============================================================================
package nios2_debug_pkg;

    localparam int c_SR_WIDTH_DEF    = 38;
    localparam int c_IR_WIDTH_DEF    = 2;
    localparam int c_NUM_CHAN_DEF    = 4;
    localparam int c_ACTION_BIT_DEF  = 34;
    localparam int c_SYNC_STAGES_DEF = 2;
    localparam int c_CNT_WIDTH_DEF   = 16;

    // Channel indices as decoded from the virtual IR
    localparam int BREAK_A   = 0;
    localparam int BREAK_B   = 1;
    localparam int OCIMEM    = 2;
    localparam int TRACECTRL = 3;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nios2_debug_slave_cmd_decoder_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : nios2_debug_sync_edge
// Purpose  : Strobe synchroniser with rising-edge detect into clk.
// Revision : 1.0 - initial release
// ============================================================================
module nios2_debug_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_delay;
    logic                   r_armed;

    // r_fill marks when the chain holds only post-reset samples; r_armed then
    // requires one low sample so a strobe high across reset is ignored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_delay <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], strobe};
            r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_delay <= r_sync[SYNC_STAGES-1];
            if (r_fill[SYNC_STAGES-1] && !r_sync[SYNC_STAGES-1]) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign rise = r_sync[SYNC_STAGES-1] & ~r_delay & r_armed;

endmodule
`default_nettype wire

// File: rtl/nios2_debug_slave_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : nios2_debug_slave_cmd_decoder
// Purpose  : Sysclk-side JTAG debug command decoder with held handshake.
// Revision : 1.0 - initial release
// ============================================================================
module nios2_debug_slave_cmd_decoder
    import nios2_debug_pkg::*;
#(
    parameter int SR_WIDTH    = c_SR_WIDTH_DEF,
    parameter int IR_WIDTH    = c_IR_WIDTH_DEF,
    parameter int NUM_CHAN    = c_NUM_CHAN_DEF,
    parameter int ACTION_BIT  = c_ACTION_BIT_DEF,
    parameter int SYNC_STAGES = c_SYNC_STAGES_DEF,
    parameter int CNT_WIDTH   = c_CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 vs_udr,
    input  logic                 vs_uir,
    input  logic [IR_WIDTH-1:0]  ir_in,
    input  logic [SR_WIDTH-1:0]  sr,
    input  logic [NUM_CHAN-1:0]  chan_en,
    input  logic                 cmd_ready,
    input  logic                 overrun_clr,
    output logic [SR_WIDTH-1:0]  jdo,
    output logic [NUM_CHAN-1:0]  take_action,
    output logic [NUM_CHAN-1:0]  take_no_action,
    output logic                 cmd_valid,
    output logic [IR_WIDTH-1:0]  cmd_chan,
    output logic                 cmd_action,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] cmd_count
);

    localparam int c_IDX_SPAN = 1 << IR_WIDTH;

    if (NUM_CHAN > c_IDX_SPAN) begin : g_bad_num_chan
        $error("NUM_CHAN exceeds 2**IR_WIDTH");
    end
    if (ACTION_BIT >= SR_WIDTH) begin : g_bad_action_bit
        $error("ACTION_BIT must be below SR_WIDTH");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("SYNC_STAGES must be at least 2");
    end

    logic w_uir_edge;
    logic w_udr_edge;

    nios2_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (vs_uir),
        .rise    (w_uir_edge)
    );

    nios2_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (vs_udr),
        .rise    (w_udr_edge)
    );

    state_t                r_state, w_state_nxt;
    logic [IR_WIDTH-1:0]   r_ir_lat;
    logic [SR_WIDTH-1:0]   r_jdo, w_jdo_nxt;
    logic [IR_WIDTH-1:0]   r_cmd_chan, w_cmd_chan_nxt;
    logic                  r_cmd_action, w_cmd_action_nxt;
    logic                  r_overrun, w_overrun_nxt;
    logic [CNT_WIDTH-1:0]  r_cmd_count, w_cmd_count_nxt;
    logic [NUM_CHAN-1:0]   r_take_action, w_take_action_nxt;
    logic [NUM_CHAN-1:0]   r_take_no_action, w_take_no_action_nxt;
    logic                  w_capture;
    logic [c_IDX_SPAN-1:0] w_en_span;
    logic                  w_chan_ok;
    logic [NUM_CHAN-1:0]   w_chan_onehot;

    // Zero padding above NUM_CHAN makes out-of-range channels read as disabled
    assign w_en_span     = c_IDX_SPAN'(chan_en);
    assign w_chan_ok     = w_en_span[r_ir_lat];
    assign w_chan_onehot = NUM_CHAN'(1) << r_ir_lat;

    always_comb begin
        w_state_nxt          = r_state;
        w_jdo_nxt            = r_jdo;
        w_cmd_chan_nxt       = r_cmd_chan;
        w_cmd_action_nxt     = r_cmd_action;
        w_cmd_count_nxt      = r_cmd_count;
        w_overrun_nxt        = r_overrun & ~overrun_clr;
        w_take_action_nxt    = '0;
        w_take_no_action_nxt = '0;
        w_capture            = 1'b0;

        case (r_state)
            IDLE: begin
                w_capture = w_udr_edge;
            end
            PENDING: begin
                if (cmd_ready) begin
                    w_state_nxt = IDLE;
                    w_capture   = w_udr_edge;
                end else if (w_udr_edge) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_capture) begin
            w_jdo_nxt        = sr;
            w_cmd_chan_nxt   = r_ir_lat;
            w_cmd_action_nxt = sr[ACTION_BIT];
            if (w_chan_ok) begin
                if (sr[ACTION_BIT]) begin
                    w_take_action_nxt = w_chan_onehot;
                end else begin
                    w_take_no_action_nxt = w_chan_onehot;
                end
                w_state_nxt     = PENDING;
                w_cmd_count_nxt = r_cmd_count + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_ir_lat         <= '0;
            r_jdo            <= '0;
            r_cmd_chan       <= '0;
            r_cmd_action     <= 1'b0;
            r_overrun        <= 1'b0;
            r_cmd_count      <= '0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_jdo            <= w_jdo_nxt;
            r_cmd_chan       <= w_cmd_chan_nxt;
            r_cmd_action     <= w_cmd_action_nxt;
            r_overrun        <= w_overrun_nxt;
            r_cmd_count      <= w_cmd_count_nxt;
            r_take_action    <= w_take_action_nxt;
            r_take_no_action <= w_take_no_action_nxt;
            if (w_uir_edge) begin
                r_ir_lat <= ir_in;
            end
        end
    end

    assign jdo            = r_jdo;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
    assign cmd_valid      = (r_state == PENDING);
    assign cmd_chan       = r_cmd_chan;
    assign cmd_action     = r_cmd_action;
    assign overrun        = r_overrun;
    assign cmd_count      = r_cmd_count;

endmodule
`default_nettype wire

// File: tb/tb_nios2_debug_slave_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_debug_slave_cmd_decoder
// Purpose  : Self-checking bench with a behavioural command-decoder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios2_debug_slave_cmd_decoder;

    localparam int SRW  = 38;
    localparam int NCH  = 4;
    localparam int ABIT = 34;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            vs_udr = 1'b0;
    logic            vs_uir = 1'b0;
    logic [1:0]      ir_in = '0;
    logic [SRW-1:0]  sr = '0;
    logic [NCH-1:0]  chan_en = 4'hF;
    logic            cmd_ready = 1'b1;
    logic            overrun_clr = 1'b0;

    logic [SRW-1:0]  jdo;
    logic [NCH-1:0]  take_action, take_no_action;
    logic            cmd_valid, cmd_action, overrun;
    logic [1:0]      cmd_chan;
    logic [15:0]     cmd_count;

    logic [SRW-1:0]  s_jdo;
    logic [NCH-1:0]  s_take_action, s_take_no_action;
    logic            s_cmd_valid, s_cmd_action, s_overrun;
    logic [1:0]      s_cmd_chan;
    logic [3:0]      s_cmd_count;

    nios2_debug_slave_cmd_decoder dut (
        .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .chan_en(chan_en), .cmd_ready(cmd_ready),
        .overrun_clr(overrun_clr), .jdo(jdo), .take_action(take_action),
        .take_no_action(take_no_action), .cmd_valid(cmd_valid),
        .cmd_chan(cmd_chan), .cmd_action(cmd_action), .overrun(overrun),
        .cmd_count(cmd_count)
    );

    // Narrow-counter instance lets the wrap be exercised within a short run
    nios2_debug_slave_cmd_decoder #(.CNT_WIDTH(4)) dut_w (
        .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .chan_en(chan_en), .cmd_ready(cmd_ready),
        .overrun_clr(overrun_clr), .jdo(s_jdo), .take_action(s_take_action),
        .take_no_action(s_take_no_action), .cmd_valid(s_cmd_valid),
        .cmd_chan(s_cmd_chan), .cmd_action(s_cmd_action), .overrun(s_overrun),
        .cmd_count(s_cmd_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           pend;
        logic [SRW-1:0] jdo;
        logic [1:0]     chan;
        logic           act;
        logic           ov;
        logic [15:0]    cnt;
        logic [1:0]     ir;
        logic [NCH-1:0] ta;
        logic [NCH-1:0] tna;
    } mstate_t;

    mstate_t m;
    bit      q_udr[$];
    bit      q_uir[$];
    int      n_vec = 0;
    int      n_bad = 0;
    bit      started = 0;
    int      ucnt = 0;
    int      icnt = 0;

    // A strobe counts when the sample two clocks back is high and the one
    // before it is a low sample taken after reset.
    function automatic bit rose(input bit q[$]);
        return q.size() >= 3 && q[q.size()-2] && !q[q.size()-3];
    endfunction

    function automatic mstate_t step(input mstate_t s, input bit eu, input bit ei,
                                     input logic [1:0] irin, input logic [SRW-1:0] srv,
                                     input logic [NCH-1:0] en, input logic rdy,
                                     input logic clr);
        mstate_t        n;
        logic [NCH-1:0] oh;
        n     = s;
        n.ta  = '0;
        n.tna = '0;
        n.ov  = s.ov & ~clr;
        if (eu) begin
            if (s.pend && !rdy) begin
                n.ov = 1'b1;
            end else begin
                n.pend = 1'b0;
                n.jdo  = srv;
                n.chan = s.ir;
                n.act  = srv[ABIT];
                if (int'(s.ir) < NCH && en[s.ir]) begin
                    oh = 4'b0001 << s.ir;
                    if (n.act) n.ta = oh;
                    else       n.tna = oh;
                    n.pend = 1'b1;
                    n.cnt  = s.cnt + 16'd1;
                end
            end
        end else if (s.pend && rdy) begin
            n.pend = 1'b0;
        end
        if (ei) n.ir = irin;
        return n;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m <= '0;
            q_udr.delete();
            q_uir.delete();
        end else begin
            m <= step(m, rose(q_udr), rose(q_uir), ir_in, sr, chan_en, cmd_ready, overrun_clr);
            q_udr.push_back(vs_udr);
            q_uir.push_back(vs_uir);
            if (q_udr.size() > 6) void'(q_udr.pop_front());
            if (q_uir.size() > 6) void'(q_uir.pop_front());
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("jdo",            64'(jdo),            64'(m.jdo));
            check("take_action",    64'(take_action),    64'(m.ta));
            check("take_no_action", 64'(take_no_action), 64'(m.tna));
            check("cmd_valid",      64'(cmd_valid),      64'(m.pend));
            check("cmd_chan",       64'(cmd_chan),       64'(m.chan));
            check("cmd_action",     64'(cmd_action),     64'(m.act));
            check("overrun",        64'(overrun),        64'(m.ov));
            check("cmd_count",      64'(cmd_count),      64'(m.cnt));
            check("cmd_count_w4",   64'(s_cmd_count),    64'(m.cnt[3:0]));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic set_ir(input logic [1:0] v);
        @(negedge clk);
        ir_in  = v;
        vs_uir = 1'b1;
        @(negedge clk) vs_uir = 1'b0;
        cycles(4);
    endtask

    initial begin
        cycles(2);
        reset_n = 1'b1;
        started = 1'b1;
        cycles(3);

        // Action command with immediate acceptance
        set_ir(2'd2);
        sr = 38'h4_0000_1234;
        vs_udr = 1'b1;
        cycles(3);
        check("t1_jdo",   64'(jdo),         64'h4_0000_1234);
        check("t1_ta",    64'(take_action), 64'h4);
        check("t1_count", 64'(cmd_count),   64'h1);
        check("t1_valid", 64'(cmd_valid),   64'h1);
        cycles(1);
        check("t1_ta_off",  64'(take_action), 64'h0);
        check("t1_valid_off", 64'(cmd_valid), 64'h0);
        vs_udr = 1'b0;
        cycles(4);

        // No-action command held while the consumer is busy, then overruns
        do_reset();
        set_ir(2'd2);
        cmd_ready = 1'b0;
        sr = 38'h0_0000_5678;
        vs_udr = 1'b1;
        cycles(3);
        check("t2_tna",    64'(take_no_action), 64'h4);
        check("t2_ta",     64'(take_action),    64'h0);
        check("t2_chan",   64'(cmd_chan),       64'h2);
        check("t2_action", 64'(cmd_action),     64'h0);
        vs_udr = 1'b0;
        cycles(2);
        check("t2_held", 64'(cmd_valid), 64'h1);
        sr = 38'h1_2345_6789;
        vs_udr = 1'b1;
        cycles(3);
        check("t3_overrun", 64'(overrun),   64'h1);
        check("t3_jdo",     64'(jdo),       64'h0_0000_5678);
        check("t3_count",   64'(cmd_count), 64'h1);
        vs_udr = 1'b0;
        cycles(2);
        vs_udr = 1'b1;
        cycles(2);
        overrun_clr = 1'b1;
        cycles(1);
        check("t3_clr_vs_new", 64'(overrun), 64'h1);
        cycles(1);
        check("t3_cleared", 64'(overrun), 64'h0);
        overrun_clr = 1'b0;
        vs_udr = 1'b0;
        cmd_ready = 1'b1;
        cycles(1);
        check("t3_accept", 64'(cmd_valid), 64'h0);
        check("t3_chan_hold", 64'(cmd_chan), 64'h2);
        cycles(3);

        // Disabled channel
        chan_en = 4'b1011;
        sr = 38'h3_0F0F_0F0F;
        vs_udr = 1'b1;
        cycles(3);
        check("t4_tna",   64'(take_no_action), 64'h0);
        check("t4_valid", 64'(cmd_valid),      64'h0);
        check("t4_jdo",   64'(jdo),            64'h3_0F0F_0F0F);
        check("t4_count", 64'(cmd_count),      64'h1);
        vs_udr = 1'b0;
        chan_en = 4'hF;
        cycles(3);

        // Strobe held across reset release
        vs_udr = 1'b1;
        sr = 38'h2_AAAA_5555;
        cycles(2);
        do_reset();
        cycles(6);
        check("t5_no_cmd",  64'(cmd_valid), 64'h0);
        check("t5_count0",  64'(cmd_count), 64'h0);
        vs_udr = 1'b0;
        cycles(3);
        vs_udr = 1'b1;
        cycles(3);
        check("t5_cmd",   64'(cmd_count), 64'h1);
        check("t5_valid", 64'(cmd_valid), 64'h1);
        vs_udr = 1'b0;
        cycles(3);

        // Randomised traffic
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (ucnt == 0) begin
                vs_udr = ~vs_udr;
                ucnt   = $urandom_range(1, 4);
            end else begin
                ucnt--;
            end
            if (!vs_udr) sr = SRW'({$urandom(), $urandom()});
            if (icnt == 0) begin
                vs_uir = ~vs_uir;
                icnt   = $urandom_range(2, 12);
            end else begin
                icnt--;
            end
            if (!vs_uir) ir_in = 2'($urandom_range(0, 3));
            cmd_ready   = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) chan_en = 4'($urandom_range(0, 15));
            reset_n = ($urandom_range(0, 1499) != 0);
        end
        reset_n = 1'b1;
        cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
